frame_stats: RTL and testbench



---
 rtl/frame_stats.sv | 220 ++++++++++++++++++++++
 tb/tb_frame_stats.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stats.sv
// frame_stats: per-frame pixel statistics and geometry checker for the NanEye
// parallel pixel stream. Accumulates sum/min/max and line geometry per frame and
// publishes a latched result set with a one-cycle STATS_VALID pulse.
// Optional feature: define FRAME_STATS_CLIP_EN to compile in the clip counter;
// without it CLIP_COUNT is tied to zero.
module frame_stats #(
  parameter int C_ROWS    = 320,
  parameter int C_COLUMNS = 320,
  parameter int D_WIDTH   = 10,
  parameter int SUM_WIDTH = 27
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 V_SYNC,
  input  logic                 H_SYNC,
  input  logic [D_WIDTH-1:0]   PIX_DATA,
  input  logic                 PIX_EN,
  output logic [SUM_WIDTH-1:0] FRAME_SUM,
  output logic [D_WIDTH-1:0]   PIX_MIN,
  output logic [D_WIDTH-1:0]   PIX_MAX,
  output logic [15:0]          LINE_COUNT,
  output logic [15:0]          BAD_LINES,
  output logic [15:0]          FRAME_COUNT,
  output logic [15:0]          CLIP_COUNT,
  output logic                 STATS_VALID,
  output logic                 FRAME_ERROR
);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_FRAME, IN_FRAME, PUBLISH} state_t;

  localparam logic [D_WIDTH-1:0]   PIX_ONES = '1;
  localparam logic [SUM_WIDTH-1:0] SUM_ONES = '1;
  localparam logic [15:0]          ROWS_16  = 16'(C_ROWS);
  localparam logic [15:0]          COLS_16  = 16'(C_COLUMNS);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t state_q, state_d;
  logic vs_q, vs_d, hs_q, hs_d, vs_rise_q, vs_rise_d;

  // per-frame accumulators
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [D_WIDTH-1:0]   min_q, min_d, max_q, max_d;
  logic [15:0]          line_cnt_q, line_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [15:0]          pix_cnt_q, pix_cnt_d;
  logic                 stray_q, stray_d;

  // published results
  logic [SUM_WIDTH-1:0] frame_sum_q, frame_sum_d;
  logic [D_WIDTH-1:0]   pix_min_q, pix_min_d, pix_max_q, pix_max_d;
  logic [15:0]          line_count_q, line_count_d, bad_lines_q, bad_lines_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 stats_valid_q, stats_valid_d;
  logic                 frame_error_q, frame_error_d;

`ifdef FRAME_STATS_CLIP_EN
  logic [15:0] clip_cnt_q, clip_cnt_d, clip_out_q, clip_out_d;
`endif

  logic                 vs_rise, vs_fall, hs_fall, pix_ok;
  logic [SUM_WIDTH:0]   sum_ext;

  assign vs_rise = V_SYNC & ~vs_q;
  assign vs_fall = ~V_SYNC & vs_q;
  assign hs_fall = ~H_SYNC & hs_q;
  assign pix_ok  = PIX_EN & H_SYNC;
  assign sum_ext = {1'b0, sum_q} + {{(SUM_WIDTH + 1 - D_WIDTH){1'b0}}, PIX_DATA};

  // next-state, accumulator and publish logic; the open line is closed before publish
  always_comb begin
    state_d       = state_q;
    vs_d          = V_SYNC;
    hs_d          = H_SYNC;
    vs_rise_d     = vs_rise;
    sum_d         = sum_q;
    min_d         = min_q;
    max_d         = max_q;
    line_cnt_d    = line_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    stray_d       = stray_q;
    frame_sum_d   = frame_sum_q;
    pix_min_d     = pix_min_q;
    pix_max_d     = pix_max_q;
    line_count_d  = line_count_q;
    bad_lines_d   = bad_lines_q;
    frame_count_d = frame_count_q;
    stats_valid_d = 1'b0;
    frame_error_d = frame_error_q;
`ifdef FRAME_STATS_CLIP_EN
    clip_cnt_d    = clip_cnt_q;
    clip_out_d    = clip_out_q;
`endif

    case (state_q)
      WAIT_LOW: begin
        if (!V_SYNC) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        // a rise seen during PUBLISH is still pending in vs_rise_q
        if (vs_rise || vs_rise_q) begin
          state_d    = IN_FRAME;
          sum_d      = '0;
          min_d      = PIX_ONES;
          max_d      = '0;
          line_cnt_d = '0;
          bad_cnt_d  = '0;
          pix_cnt_d  = '0;
          stray_d    = 1'b0;
`ifdef FRAME_STATS_CLIP_EN
          clip_cnt_d = '0;
`endif
        end
      end
      IN_FRAME: begin
        if (pix_ok) begin
          sum_d     = sum_ext[SUM_WIDTH] ? SUM_ONES : sum_ext[SUM_WIDTH-1:0];
          if (PIX_DATA < min_q) min_d = PIX_DATA;
          if (PIX_DATA > max_q) max_d = PIX_DATA;
          pix_cnt_d = sat_inc(pix_cnt_q);
`ifdef FRAME_STATS_CLIP_EN
          if (PIX_DATA == '0 || PIX_DATA == PIX_ONES) clip_cnt_d = sat_inc(clip_cnt_q);
`endif
        end
        if (PIX_EN && !H_SYNC) stray_d = 1'b1;
        if (hs_fall || (vs_fall && H_SYNC)) begin
          line_cnt_d = sat_inc(line_cnt_q);
          if (!hs_fall || pix_cnt_q != COLS_16) bad_cnt_d = sat_inc(bad_cnt_q);
          pix_cnt_d  = '0;
        end
        if (vs_fall) state_d = PUBLISH;
      end
      PUBLISH: begin
        frame_sum_d   = sum_q;
        pix_min_d     = min_q;
        pix_max_d     = max_q;
        line_count_d  = line_cnt_q;
        bad_lines_d   = bad_cnt_q;
        frame_count_d = frame_count_q + 16'd1;
        frame_error_d = (line_cnt_q != ROWS_16) || (bad_cnt_q != 16'd0) || stray_q;
        stats_valid_d = 1'b1;
`ifdef FRAME_STATS_CLIP_EN
        clip_out_d    = clip_cnt_q;
`endif
        state_d       = WAIT_FRAME;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // state and output registers; reset abandons any frame in progress
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= WAIT_LOW;
      vs_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_rise_q     <= 1'b0;
      sum_q         <= '0;
      min_q         <= '0;
      max_q         <= '0;
      line_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      stray_q       <= 1'b0;
      frame_sum_q   <= '0;
      pix_min_q     <= '0;
      pix_max_q     <= '0;
      line_count_q  <= '0;
      bad_lines_q   <= '0;
      frame_count_q <= '0;
      stats_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef FRAME_STATS_CLIP_EN
      clip_cnt_q    <= '0;
      clip_out_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      hs_q          <= hs_d;
      vs_rise_q     <= vs_rise_d;
      sum_q         <= sum_d;
      min_q         <= min_d;
      max_q         <= max_d;
      line_cnt_q    <= line_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      stray_q       <= stray_d;
      frame_sum_q   <= frame_sum_d;
      pix_min_q     <= pix_min_d;
      pix_max_q     <= pix_max_d;
      line_count_q  <= line_count_d;
      bad_lines_q   <= bad_lines_d;
      frame_count_q <= frame_count_d;
      stats_valid_q <= stats_valid_d;
      frame_error_q <= frame_error_d;
`ifdef FRAME_STATS_CLIP_EN
      clip_cnt_q    <= clip_cnt_d;
      clip_out_q    <= clip_out_d;
`endif
    end
  end

  assign FRAME_SUM   = frame_sum_q;
  assign PIX_MIN     = pix_min_q;
  assign PIX_MAX     = pix_max_q;
  assign LINE_COUNT  = line_count_q;
  assign BAD_LINES   = bad_lines_q;
  assign FRAME_COUNT = frame_count_q;
  assign STATS_VALID = stats_valid_q;
  assign FRAME_ERROR = frame_error_q;
`ifdef FRAME_STATS_CLIP_EN
  assign CLIP_COUNT  = clip_out_q;
`else
  assign CLIP_COUNT  = 16'd0;
`endif

endmodule

// File: tb/tb_frame_stats.sv
// tb_frame_stats: drives directed and random frames into frame_stats and compares
// every published result set against a frame-level reference model.
module tb_frame_stats;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DW     = 10;
  localparam int SW     = 13;
  localparam int PIXMAX = 1023;
  localparam int SUMMAX = 8191;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          V_SYNC, H_SYNC, PIX_EN;
  logic [DW-1:0] PIX_DATA;
  logic [SW-1:0] FRAME_SUM;
  logic [DW-1:0] PIX_MIN, PIX_MAX;
  logic [15:0]   LINE_COUNT, BAD_LINES, FRAME_COUNT, CLIP_COUNT;
  logic          STATS_VALID, FRAME_ERROR;

  frame_stats #(.C_ROWS(ROWS), .C_COLUMNS(COLS), .D_WIDTH(DW), .SUM_WIDTH(SW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .V_SYNC(V_SYNC), .H_SYNC(H_SYNC),
    .PIX_DATA(PIX_DATA), .PIX_EN(PIX_EN), .FRAME_SUM(FRAME_SUM),
    .PIX_MIN(PIX_MIN), .PIX_MAX(PIX_MAX), .LINE_COUNT(LINE_COUNT),
    .BAD_LINES(BAD_LINES), .FRAME_COUNT(FRAME_COUNT), .CLIP_COUNT(CLIP_COUNT),
    .STATS_VALID(STATS_VALID), .FRAME_ERROR(FRAME_ERROR)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // frame description: lines with their pixel values, plus end-of-frame variants
  int nLines;
  int lineLen [8];
  int pix [8][8];
  bit openEnd, simEnd;
  int strayVal;

  int expSum, expMin, expMax, expLines, expBad, expClip, expErr;
  int expFrameCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_sum"}, FRAME_SUM, 0);
    checkOutput({name, "_min"}, PIX_MIN, 0);
    checkOutput({name, "_max"}, PIX_MAX, 0);
    checkOutput({name, "_lines"}, LINE_COUNT, 0);
    checkOutput({name, "_bad"}, BAD_LINES, 0);
    checkOutput({name, "_count"}, FRAME_COUNT, 0);
    checkOutput({name, "_clip"}, CLIP_COUNT, 0);
    checkOutput({name, "_valid"}, STATS_VALID, 0);
    checkOutput({name, "_error"}, FRAME_ERROR, 0);
  endtask

  // frame-level reference: statistics over all in-line pixels, geometry from line lengths
  task automatic computeExpected();
    longint s = 0;
    int mn = PIXMAX, mx = 0, bad = 0, clip = 0;
    for (int l = 0; l < nLines; l++) begin
      for (int p = 0; p < lineLen[l]; p++) begin
        s += pix[l][p];
        if (pix[l][p] < mn) mn = pix[l][p];
        if (pix[l][p] > mx) mx = pix[l][p];
        if (pix[l][p] == 0 || pix[l][p] == PIXMAX) clip++;
      end
      if (lineLen[l] != COLS || (openEnd && l == nLines - 1)) bad++;
    end
    expSum   = (s > SUMMAX) ? SUMMAX : int'(s);
    expMin   = mn;
    expMax   = mx;
    expLines = nLines;
    expBad   = bad;
    expErr   = (nLines != ROWS || bad != 0 || strayVal >= 0) ? 1 : 0;
`ifdef FRAME_STATS_CLIP_EN
    expClip  = clip;
`else
    expClip  = 0;
`endif
    expFrameCount = (expFrameCount + 1) % 65536;
  endtask

  task automatic fillFrame(input int lines, input int len);
    nLines = lines;
    for (int l = 0; l < 8; l++) begin
      lineLen[l] = len;
      for (int p = 0; p < 8; p++) pix[l][p] = l * len + p + 1;
    end
    openEnd  = 0;
    simEnd   = 0;
    strayVal = -1;
  endtask

  task automatic randomFrame();
    nLines = $urandom_range(3, 5);
    for (int l = 0; l < 8; l++) begin
      lineLen[l] = ($urandom_range(0, 1) == 1) ? COLS : $urandom_range(3, 5);
      for (int p = 0; p < 8; p++) begin
        case ($urandom_range(0, 7))
          0:       pix[l][p] = 0;
          1:       pix[l][p] = PIXMAX;
          default: pix[l][p] = $urandom_range(1, PIXMAX - 1);
        endcase
      end
    end
    openEnd = 0;
    simEnd  = 0;
    case ($urandom_range(0, 3))
      1:       simEnd = 1;
      2:       openEnd = 1;
      default: ;
    endcase
    strayVal = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PIXMAX) : -1;
  endtask

  // drives one frame from the description; called at a negedge, returns with V_SYNC just dropped
  task automatic applyStimulus();
    V_SYNC = 1; H_SYNC = 0; PIX_EN = 0;
    @(negedge CLOCK);
    if (strayVal >= 0) begin
      PIX_EN = 1; PIX_DATA = DW'(strayVal);
    end
    @(negedge CLOCK);
    PIX_EN = 0;
    for (int l = 0; l < nLines; l++) begin
      H_SYNC = 1;
      @(negedge CLOCK);
      for (int p = 0; p < lineLen[l]; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          PIX_EN = 0;
          @(negedge CLOCK);
        end
        PIX_EN = 1; PIX_DATA = DW'(pix[l][p]);
        @(negedge CLOCK);
      end
      PIX_EN = 0;
      if (l == nLines - 1 && openEnd) begin
        H_SYNC = 1;
      end else if (l == nLines - 1 && simEnd) begin
        H_SYNC = 0;
      end else begin
        H_SYNC = 0;
        @(negedge CLOCK);
      end
    end
    V_SYNC = 0;
  endtask

  task automatic observePublish(input string name);
    int lat = 0;
    do begin
      @(negedge CLOCK);
      H_SYNC = 0;
      lat++;
    end while (STATS_VALID !== 1'b1 && lat < 10);
    checkOutput({name, "_latency"}, lat, 2);
    checkOutput({name, "_sum"}, FRAME_SUM, expSum);
    checkOutput({name, "_min"}, PIX_MIN, expMin);
    checkOutput({name, "_max"}, PIX_MAX, expMax);
    checkOutput({name, "_lines"}, LINE_COUNT, expLines);
    checkOutput({name, "_bad"}, BAD_LINES, expBad);
    checkOutput({name, "_count"}, FRAME_COUNT, expFrameCount);
    checkOutput({name, "_clip"}, CLIP_COUNT, expClip);
    checkOutput({name, "_error"}, FRAME_ERROR, expErr);
    @(negedge CLOCK);
    checkOutput({name, "_pulse_end"}, STATS_VALID, 0);
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic runFrame(input string name);
    computeExpected();
    applyStimulus();
    observePublish(name);
  endtask

  task automatic countQuietValids(input string name);
    int seen = 0;
    repeat (8) begin
      @(negedge CLOCK);
      if (STATS_VALID === 1'b1) seen++;
    end
    checkOutput(name, seen, 0);
  endtask

  // directed scenarios first, then random frames, then a mid-frame reset
  initial begin
    RESET = 1; V_SYNC = 0; H_SYNC = 0; PIX_EN = 0; PIX_DATA = '0;
    repeat (3) @(negedge CLOCK);
    checkResetState("reset");

    V_SYNC = 1;
    @(negedge CLOCK);
    RESET = 0;
    H_SYNC = 1;
    repeat (3) begin
      PIX_EN = 1; PIX_DATA = 10'd7;
      @(negedge CLOCK);
    end
    PIX_EN = 0; H_SYNC = 0;
    @(negedge CLOCK);
    V_SYNC = 0;
    countQuietValids("partial_no_valid");
    checkOutput("partial_count", FRAME_COUNT, 0);

    fillFrame(4, 4);
    runFrame("nominal");
    checkOutput("nominal_sum_const", FRAME_SUM, 136);
    checkOutput("nominal_count_const", FRAME_COUNT, 1);

    fillFrame(4, 4);
    lineLen[1] = 3;
    runFrame("badline");
    checkOutput("badline_bad_const", BAD_LINES, 1);

    fillFrame(4, 4);
    simEnd = 1;
    runFrame("simend");
    checkOutput("simend_error_const", FRAME_ERROR, 0);

    fillFrame(4, 4);
    strayVal = 999;
    runFrame("stray");
    checkOutput("stray_max_const", PIX_MAX, 16);

    fillFrame(4, 4);
    pix[0][0] = 0; pix[0][1] = PIXMAX; pix[0][2] = PIXMAX; pix[0][3] = 5;
    runFrame("clip");
`ifdef FRAME_STATS_CLIP_EN
    checkOutput("clip_const", CLIP_COUNT, 3);
`else
    checkOutput("clip_const", CLIP_COUNT, 0);
`endif

    fillFrame(4, 4);
    openEnd = 1;
    runFrame("openend");

    fillFrame(0, 4);
    runFrame("empty");
    checkOutput("empty_min_const", PIX_MIN, PIXMAX);

    fillFrame(4, 4);
    for (int l = 0; l < 8; l++)
      for (int p = 0; p < 8; p++) pix[l][p] = PIXMAX;
    runFrame("saturate");

    for (int i = 0; i < 8; i++) begin
      randomFrame();
      runFrame($sformatf("random%0d", i));
    end

    V_SYNC = 1;
    @(negedge CLOCK);
    H_SYNC = 1; PIX_EN = 1; PIX_DATA = 10'd100;
    repeat (2) @(negedge CLOCK);
    RESET = 1; PIX_EN = 0;
    repeat (2) @(negedge CLOCK);
    checkResetState("midreset");
    RESET = 0;
    repeat (2) @(negedge CLOCK);
    H_SYNC = 0;
    @(negedge CLOCK);
    V_SYNC = 0;
    countQuietValids("midreset_no_valid");
    expFrameCount = 0;
    randomFrame();
    runFrame("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
